// File: rtl/dram_bytewr.sv
// dram_bytewr: single-port synchronous data RAM with per-byte write enables,
// selectable read latency (RD_LAT = 1 or 2), read-valid pulse and a
// self-clearing sequence that zeroes the array after every reset.
// Optional per-lane even parity is compiled in with macro DRAM_PARITY_EN.
//
// Ports:
//   clka       : clock, all logic on rising edge
//   rsta       : synchronous active-high reset, restarts the clear sequence
//   ena        : access enable (accepted when busy is low)
//   wea        : byte write enables; nonzero = write, zero = read
//   addra      : word address
//   dina       : write data
//   douta      : read data, holds last read result
//   rd_valid   : one-cycle pulse when douta carries a fresh read result
//   busy       : high while the clear sequence runs
//   parity_err : parity error flag qualified by rd_valid (0 without parity)
module dram_bytewr #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  output logic                rd_valid,
  output logic                busy,
  output logic                parity_err
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                busy_q, busy_d;
  logic                clr_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                acc, wr_fire, rd_fire, in_range;
  logic [DATA_W-1:0]   rd_raw, rd_word;
  logic                rd_perr;

  logic                s1_v_q, s1_perr_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic                out_v, out_perr;
  logic [DATA_W-1:0]   out_data;

  logic [DATA_W-1:0]   douta_q;
  logic                rd_valid_q, perr_q;

  // Clear FSM state register
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Clear FSM next state: one word zeroed per cycle, READY after the last word
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    clr_we     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_READY;
          busy_d     = 1'b0;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      S_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = S_CLEAR;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Access qualification; reset wins over any access at the same edge
  always_comb begin
    acc      = ena && !busy_q && !rsta;
    wr_fire  = acc && (|wea);
    rd_fire  = acc && !(|wea);
    in_range = {1'b0, addra} < AW1'(DEPTH);
    rd_raw   = mem_q[addra];
    rd_word  = in_range ? rd_raw : '0;
  end

  // Data array: clear writes and byte-lane writes are mutually exclusive via busy
  always_ff @(posedge clka) begin
    if (!rsta && clr_we) begin
      mem_q[clr_addr_q] <= '0;
    end else if (wr_fire && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

`ifdef DRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] par_calc;

  // Parity array: one even-parity bit per lane, updated only for written lanes
  always_ff @(posedge clka) begin
    if (!rsta && clr_we) begin
      par_q[clr_addr_q] <= '0;
    end else if (wr_fire && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) par_q[addra][i] <= ^dina[8*i +: 8];
      end
    end
  end

  // Recompute lane parity of the stored word and compare with stored bits
  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NB; i++) par_calc[i] = ^rd_raw[8*i +: 8];
    rd_perr = in_range && (|(par_calc ^ par_q[addra]));
  end
`else
  always_comb rd_perr = 1'b0;
`endif

  // Output select: direct from array read or from the extra stage when RD_LAT=2
  always_comb begin
    if (RD_LAT == 2) begin
      out_v    = s1_v_q;
      out_data = s1_data_q;
      out_perr = s1_perr_q;
    end else begin
      out_v    = rd_fire;
      out_data = rd_word;
      out_perr = rd_perr;
    end
  end

  // Read pipeline and output registers; douta holds until the next result
  always_ff @(posedge clka) begin
    if (rsta) begin
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_perr_q  <= 1'b0;
      douta_q    <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      s1_v_q <= rd_fire;
      if (rd_fire) begin
        s1_data_q <= rd_word;
        s1_perr_q <= rd_perr;
      end
      rd_valid_q <= out_v;
      if (out_v) begin
        douta_q <= out_data;
        perr_q  <= out_perr;
      end
    end
  end

  assign douta      = douta_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_dram_bytewr.sv
// Directed bench for dram_bytewr. Three instances share one stimulus stream:
// d0 default (RD_LAT=1, DEPTH=256), d1 with RD_LAT=2, d2 with DEPTH=200.
module tb_dram_bytewr;

  logic        clk;
  logic        rsta;
  logic        ena;
  logic [3:0]  wea;
  logic [7:0]  addra;
  logic [31:0] dina;

  logic [31:0] d0_dout, d1_dout, d2_dout;
  logic        d0_v, d1_v, d2_v;
  logic        d0_busy, d1_busy, d2_busy;
  logic        d0_perr, d1_perr, d2_perr;

  int ncmp  = 0;
  int nfail = 0;

  dram_bytewr u_d0 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(d0_dout), .rd_valid(d0_v), .busy(d0_busy), .parity_err(d0_perr)
  );

  dram_bytewr #(.RD_LAT(2)) u_d1 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(d1_dout), .rd_valid(d1_v), .busy(d1_busy), .parity_err(d1_perr)
  );

  dram_bytewr #(.DEPTH(200)) u_d2 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(d2_dout), .rd_valid(d2_v), .busy(d2_busy), .parity_err(d2_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [7:0] a,
                       input logic [31:0] d);
    ena   = e;
    wea   = w;
    addra = a;
    dina  = d;
  endtask

  initial begin
    int cnt;
    int n2;
    int saw_v;

    rsta = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 32'h0);

    // 1. reset state, clear length, reads of cleared words
    tick();
    tick();
    check("rst_douta", d0_dout, 32'h0);
    check("rst_valid", 32'(d0_v), 32'h0);
    check("rst_busy", 32'(d0_busy), 32'h1);
    check("rst_perr", 32'(d0_perr), 32'h0);
    rsta = 1'b0;
    cnt = 0;
    n2  = 0;
    while (d0_busy === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
      if (d2_busy === 1'b0 && n2 == 0) n2 = cnt;
    end
    check("clear_cycles_256", 32'(cnt), 32'd256);
    check("clear_cycles_200", 32'(n2), 32'd200);

    drive(1'b1, 4'h0, 8'h00, 32'h0);
    tick();
    check("rd00_valid", 32'(d0_v), 32'h1);
    check("rd00_data", d0_dout, 32'h0);
    check("rd00_lat2_notyet", 32'(d1_v), 32'h0);
    drive(1'b1, 4'h0, 8'hFF, 32'h0);
    tick();
    check("rdFF_valid", 32'(d0_v), 32'h1);
    check("rdFF_data", d0_dout, 32'h0);
    check("rd00_lat2_valid", 32'(d1_v), 32'h1);
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    check("idle_novalid", 32'(d0_v), 32'h0);
    check("rdFF_lat2_valid", 32'(d1_v), 32'h1);
    check("rdFF_lat2_data", d1_dout, 32'h0);

    // 2. partial byte write merge
    drive(1'b1, 4'hF, 8'h10, 32'h11223344);
    tick();
    check("wr_no_valid", 32'(d0_v), 32'h0);
    drive(1'b1, 4'b0101, 8'h10, 32'hAABBCCDD);
    tick();
    check("wr_douta_hold", d0_dout, 32'h0);
    drive(1'b1, 4'h0, 8'h10, 32'h0);
    tick();
    check("merge_valid", 32'(d0_v), 32'h1);
    check("merge_data", d0_dout, 32'h11BB33DD);
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    check("merge_hold", d0_dout, 32'h11BB33DD);
    check("merge_hold_novalid", 32'(d0_v), 32'h0);
    check("merge_lat2_data", d1_dout, 32'h11BB33DD);
    check("merge_lat2_valid", 32'(d1_v), 32'h1);

    // 3. streaming writes then back-to-back reads
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 4'hF, 8'(n), 32'(2 * n));
      tick();
    end
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 4'h0, 8'(n), 32'h0);
      tick();
      check("stream_valid", 32'(d0_v), 32'h1);
      check("stream_data", d0_dout, 32'(2 * n));
      if (n >= 1) begin
        check("stream_lat2_valid", 32'(d1_v), 32'h1);
        check("stream_lat2_data", d1_dout, 32'(2 * (n - 1)));
      end
    end
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    check("stream_lat2_last_valid", 32'(d1_v), 32'h1);
    check("stream_lat2_last_data", d1_dout, 32'd30);
    check("stream_end_novalid", 32'(d0_v), 32'h0);

    // 5. out-of-range access on the DEPTH=200 instance
    drive(1'b1, 4'hF, 8'hC7, 32'hCAFEF00D);
    tick();
    drive(1'b1, 4'hF, 8'hC8, 32'h12345678);
    tick();
    drive(1'b1, 4'h0, 8'hC8, 32'h0);
    tick();
    check("oor_valid", 32'(d2_v), 32'h1);
    check("oor_data", d2_dout, 32'h0);
    check("oor_perr", 32'(d2_perr), 32'h0);
    check("inrange_C8_d0", d0_dout, 32'h12345678);
    drive(1'b1, 4'h0, 8'hC7, 32'h0);
    tick();
    check("C7_valid", 32'(d2_v), 32'h1);
    check("C7_data", d2_dout, 32'hCAFEF00D);

    // 4. reset in the middle of the clear sequence
    drive(1'b1, 4'hF, 8'hC0, 32'hDEADBEEF);
    tick();
    drive(1'b1, 4'h0, 8'hC0, 32'h0);
    tick();
    check("C0_before", d0_dout, 32'hDEADBEEF);
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    rsta = 1'b1;
    tick();
    check("rst2_douta", d0_dout, 32'h0);
    check("rst2_busy", 32'(d0_busy), 32'h1);
    check("rst2_valid", 32'(d0_v), 32'h0);
    rsta = 1'b0;
    drive(1'b1, 4'h0, 8'hC0, 32'h0);
    saw_v = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (d0_v === 1'b1) saw_v++;
    end
    check("busy_drop_reads", 32'(saw_v), 32'h0);
    check("busy_mid", 32'(d0_busy), 32'h1);
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    cnt = 0;
    while (d0_busy === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    check("restart_cycles", 32'(cnt), 32'd256);
    check("no_queued_read", 32'(d0_v), 32'h0);
    drive(1'b1, 4'h0, 8'hC0, 32'h0);
    tick();
    check("C0_cleared_valid", 32'(d0_v), 32'h1);
    check("C0_cleared_data", d0_dout, 32'h0);
    check("perr_default", 32'(d0_perr), 32'h0);
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
